// File: rtl/contrast_pkg.sv
// Shared defaults, pivot mid-point helper and pending-request encoding for the
// contrast pipeline.
package contrast_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int CH_DEF        = 3;
  localparam int LVL_W_DEF     = 4;
  localparam int FRAC_W_DEF    = 3;
  localparam int LVL_RST_DEF   = 8;
  localparam int AVG_SHIFT_DEF = 10;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DOWN = 2'd2
  } req_e;

  function automatic int unsigned mid_point(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/contrast_chan.sv
// One colour channel of the contrast datapath: stage 1 forms |x-pivot|*level,
// stage 2 shifts, adds/subtracts around the pivot and saturates.
module contrast_chan
  import contrast_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LVL_W  = LVL_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] pivot,
  input  logic [LVL_W-1:0]  level,
  output logic [DATA_W-1:0] y
);

  localparam int PW = DATA_W + LVL_W;
  localparam logic [PW:0] SAT_MAX = (PW+1)'((1 << DATA_W) - 1);

  logic              gt_q, gt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [DATA_W-1:0] piv_q, piv_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] diff;
  logic [PW-1:0]     p;
  logic [PW:0]       up;

  always_comb begin
    gt_d   = x > pivot;
    diff   = gt_d ? x - pivot : pivot - x;
    prod_d = PW'(diff) * PW'(level);
    piv_d  = pivot;

    // The pivot travels with the pixel so a pivot reload cannot tear a pixel.
    p  = prod_q >> FRAC_W;
    up = (PW+1)'(piv_q) + (PW+1)'(p);
    if (gt_q) y_d = (up > SAT_MAX) ? '1 : up[DATA_W-1:0];
    else      y_d = (p > PW'(piv_q)) ? '0 : piv_q - p[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use <= so every register samples the pre-edge values.
    if (rst) begin
      gt_q   <= 1'b0;
      prod_q <= '0;
      piv_q  <= '0;
      y_q    <= '0;
    end else begin
      gt_q   <= gt_d;
      prod_q <= prod_d;
      piv_q  <= piv_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/contrast_pipe.sv
// Contrast stretch around a pivot with frame-synchronous level control.
// Define CONTRAST_PIVOT_AVG_EN to track the pivot as the per-frame channel mean.
module contrast_pipe
  import contrast_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CH      = CH_DEF,
  parameter int LVL_W   = LVL_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int LVL_RST = LVL_RST_DEF
`ifdef CONTRAST_PIVOT_AVG_EN
  , parameter int AVG_SHIFT = AVG_SHIFT_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_en,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]     level
);

  localparam logic [LVL_W-1:0]  UNITY     = LVL_W'(1 << FRAC_W);
  localparam logic [LVL_W-1:0]  LVL_MAX   = '1;
  localparam logic [DATA_W-1:0] PIVOT_MID = DATA_W'(mid_point(DATA_W));

  logic                     inc_q, inc_d, dec_q, dec_d;
  logic                     inc_rise, dec_rise;
  logic                     active_q, active_d;
  req_e                     pend_q, pend_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     v1_q, v1_d, v2_q, v2_d;
  logic [LVL_W-1:0]         eff_level;
  logic [CH-1:0][DATA_W-1:0] pivot;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    inc_d    = inc;
    dec_d    = dec;
    inc_rise = inc & ~inc_q;
    dec_rise = dec & ~dec_q;
    active_d = frame_en ? enable : active_q;
    pend_d   = pend_q;
    level_d  = level_q;
    v1_d     = in_valid;
    v2_d     = v1_q;

    if (active_q) begin
      if (frame_en) begin
        if (pend_q == REQ_UP && level_q != LVL_MAX)
          level_d = level_q + LVL_W'(1);
        else if (pend_q == REQ_DOWN && level_q != '0)
          level_d = level_q - LVL_W'(1);
        pend_d = REQ_NONE;
      end
      // Coincident edges cancel each other and leave any earlier request alone.
      if (inc_rise != dec_rise) pend_d = inc_rise ? REQ_UP : REQ_DOWN;
    end else begin
      pend_d = REQ_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      active_q <= 1'b0;
      pend_q   <= REQ_NONE;
      level_q  <= LVL_W'(LVL_RST);
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
    end
  end

`ifdef CONTRAST_PIVOT_AVG_EN
  localparam int SW = DATA_W + AVG_SHIFT;
  localparam logic [AVG_SHIFT:0] FULL = (AVG_SHIFT+1)'(1 << AVG_SHIFT);

  logic [CH-1:0][DATA_W-1:0] pivot_q, pivot_d;
  logic [CH-1:0][SW-1:0]     sum_q, sum_d;
  logic [AVG_SHIFT:0]        cnt_q, cnt_d;

  always_comb begin
    pivot_d = pivot_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (frame_en) begin
      for (int c = 0; c < CH; c++) begin
        if (cnt_q == FULL) pivot_d[c] = DATA_W'(sum_q[c] >> AVG_SHIFT);
        sum_d[c] = '0;
      end
      cnt_d = '0;
    end else if (in_valid && cnt_q != FULL) begin
      for (int c = 0; c < CH; c++)
        sum_d[c] = sum_q[c] + SW'(in_data[c*DATA_W +: DATA_W]);
      cnt_d = cnt_q + (AVG_SHIFT+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pivot_q <= {CH{PIVOT_MID}};
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pivot_q <= pivot_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pivot = pivot_q;
`else
  assign pivot = {CH{PIVOT_MID}};
`endif

  // Unity gain reproduces x exactly, so bypass reuses the same pipeline.
  assign eff_level = active_q ? level_q : UNITY;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    contrast_chan #(
      .DATA_W(DATA_W),
      .LVL_W (LVL_W),
      .FRAC_W(FRAC_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .x    (in_data[c*DATA_W +: DATA_W]),
      .pivot(pivot[c]),
      .level(eff_level),
      .y    (out_data[c*DATA_W +: DATA_W])
    );
  end

  assign out_valid = v2_q;
  assign level     = level_q;

endmodule

// File: tb/tb_contrast_pipe.sv
// Self-checking bench for contrast_pipe: directed literal cases plus a random
// run compared every cycle against a behavioural model.
module tb_contrast_pipe;

  localparam int FW = 3;
`ifdef CONTRAST_PIVOT_AVG_EN
  localparam int AS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, frame_en, inc, dec, in_valid;
  logic [23:0] in_data;
  logic        out_valid;
  logic [23:0] out_data;
  logic [3:0]  level;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state: level control, expected pipeline contents, pivots.
  int          m_level  = 8;
  int          m_pend   = 0;
  bit          m_active = 1'b0;
  bit          m_inc    = 1'b0;
  bit          m_dec    = 1'b0;
  bit          e1v      = 1'b0;
  bit          e2v      = 1'b0;
  logic [23:0] e1d      = '0;
  logic [23:0] e2d      = '0;
  int          m_piv[3] = '{128, 128, 128};
  int          m_sum[3] = '{0, 0, 0};
  int          m_cnt    = 0;

  always #5 clk = ~clk;

  contrast_pipe #(
    .DATA_W (8),
    .CH     (3),
    .LVL_W  (4),
    .FRAC_W (FW),
    .LVL_RST(8)
`ifdef CONTRAST_PIVOT_AVG_EN
    , .AVG_SHIFT(AS)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .frame_en (frame_en),
    .inc      (inc),
    .dec      (dec),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .level    (level)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
  endtask

  function automatic logic [23:0] xform(input logic [23:0] px, input int lvl, input bit act);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int x, piv, p, y;
      x   = int'(px[c*8 +: 8]);
      piv = m_piv[c];
      if (!act) y = x;
      else if (x > piv) begin
        p = ((x - piv) * lvl) >> FW;
        y = (piv + p > 255) ? 255 : piv + p;
      end else begin
        p = ((piv - x) * lvl) >> FW;
        y = (p > piv) ? 0 : piv - p;
      end
      r[c*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  // Advance the model by one clock, reading the inputs the DUT samples.
  task automatic model_tick();
    bit inc_r, dec_r;
    if (rst) begin
      m_level = 8; m_pend = 0; m_active = 1'b0; m_inc = 1'b0; m_dec = 1'b0;
      e1v = 1'b0; e2v = 1'b0; e2d = '0;
      m_piv = '{128, 128, 128}; m_sum = '{0, 0, 0}; m_cnt = 0;
      return;
    end
    e2v = e1v;
    e2d = e1d;
    e1v = in_valid;
    e1d = xform(in_data, m_level, m_active);
    inc_r = inc && !m_inc;
    dec_r = dec && !m_dec;
    m_inc = inc;
    m_dec = dec;
    if (m_active) begin
      if (frame_en) begin
        m_level = m_level + m_pend;
        if (m_level > 15) m_level = 15;
        if (m_level < 0)  m_level = 0;
        m_pend = 0;
      end
      if (inc_r && !dec_r) m_pend = 1;
      else if (dec_r && !inc_r) m_pend = -1;
    end else begin
      m_pend = 0;
    end
    if (frame_en) m_active = enable;
`ifdef CONTRAST_PIVOT_AVG_EN
    if (frame_en) begin
      if (m_cnt == (1 << AS))
        for (int c = 0; c < 3; c++) m_piv[c] = m_sum[c] >> AS;
      m_sum = '{0, 0, 0};
      m_cnt = 0;
    end else if (in_valid && m_cnt < (1 << AS)) begin
      for (int c = 0; c < 3; c++) m_sum[c] += int'(in_data[c*8 +: 8]);
      m_cnt++;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic bump_level(input int n);
    repeat (n) begin
      inc = 1'b1; step();
      inc = 1'b0; frame_en = 1'b1; step();
      frame_en = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, e2v);
      if (e2v) check("out_data", out_data, e2d);
      check("level", level, m_level);
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; frame_en = 1'b0; inc = 1'b0; dec = 1'b0;
    in_valid = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    check("rst_level", level, 8);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    chk_en = 1'b1;

    // Activate, then unity gain passes the pixel through.
    enable = 1'b1; frame_en = 1'b1; step(); frame_en = 1'b0;
    in_valid = 1'b1; in_data = 24'h404040; step();
    in_valid = 1'b0; step();
    check("unity_valid", out_valid, 1);
    check("unity_data", out_data, 24'h404040);

    // Maximum gain with clamping at both rails.
    bump_level(7);
    check("level_max", level, 15);
    in_valid = 1'b1; in_data = 24'hFF10C0; step();
    in_valid = 1'b0; step();
    check("max_gain_valid", out_valid, 1);
    check("max_gain_data", out_data, 24'hFF00F8);

    // No wrap past the top level.
    inc = 1'b1; step();
    frame_en = 1'b1; step();
    frame_en = 1'b0; inc = 1'b0; step();
    check("level_sat", level, 15);

    // Reset with pixels in flight.
    in_valid = 1'b1; in_data = 24'h123456; step();
    in_data = 24'hABCDEF; step();
    rst = 1'b1; in_valid = 1'b0; step();
    rst = 1'b0;
    check("rst_flight_valid", out_valid, 0);
    check("rst_flight_level", level, 8);

    // Held inc across a frame boundary gives exactly one step.
    frame_en = 1'b1; step(); frame_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      inc = 1'b1; frame_en = (i == 10); step();
    end
    inc = 1'b0; frame_en = 1'b0;
    check("held_inc_level", level, 9);
    frame_en = 1'b1; step(); frame_en = 1'b0;
    check("held_inc_once", level, 9);

    // Coincident edges cancel.
    inc = 1'b1; dec = 1'b1; step();
    inc = 1'b0; dec = 1'b0; frame_en = 1'b1; step(); frame_en = 1'b0;
    check("cancel_level", level, 9);

    // Enable raised mid-frame: bypass until the cycle after frame_en.
    bump_level(6);
    enable = 1'b0; frame_en = 1'b1; step(); frame_en = 1'b0;
    enable = 1'b1; in_valid = 1'b1; in_data = 24'hC0C0C0; step();
    frame_en = 1'b1; step();
    frame_en = 1'b0; step();
    in_valid = 1'b0;
    check("en_bypass_data", out_data, 24'hC0C0C0);
    step();
    check("en_active_data", out_data, 24'hF8F8F8);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      enable   = ($urandom_range(0, 15) == 0) ? ~enable : enable;
      frame_en = ($urandom_range(0, 23) == 0);
      inc      = ($urandom_range(0, 5) == 0) ? ~inc : inc;
      dec      = ($urandom_range(0, 5) == 0) ? ~dec : dec;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 24'($urandom);
      step();
    end
    rst = 1'b0; frame_en = 1'b0; inc = 1'b0; dec = 1'b0; in_valid = 1'b0;

`ifdef CONTRAST_PIVOT_AVG_EN
    rst = 1'b1; step(); rst = 1'b0;
    enable = 1'b1; frame_en = 1'b1; step(); frame_en = 1'b0;
    bump_level(7);
    in_valid = 1'b1; in_data = 24'h303030;
    repeat (16) step();
    in_valid = 1'b0; frame_en = 1'b1; step(); frame_en = 1'b0;
    in_valid = 1'b1; in_data = 24'h303030; step();
    in_data = 24'h202020; step();
    in_valid = 1'b0;
    check("avg_pivot_data", out_data, 24'h303030);
    step();
    check("avg_below_data", out_data, 24'h121212);
`endif

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
